// File: rtl/aes_key_sched.sv
// AES-128 key schedule: expands one cipher key into 11 stored round keys (one per cycle),
// then streams them forward or reverse over valid/ready with registered outputs.
module aes_key_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid_i,
  input  logic [127:0] key_i,
  output logic         busy_o,
  output logic         keys_ready_o,
  input  logic         rk_req_i,
  input  logic         decrypt_i,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         rk_last_o
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY, STREAM} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         dec_q, dec_d;
  logic         busy_q, busy_d;
  logic         keys_ready_q, keys_ready_d;
  logic         rk_valid_q, rk_valid_d;
  logic [127:0] rk_dat_q, rk_dat_d;
  logic [3:0]   rk_idx_q, rk_idx_d;
  logic         rk_last_q, rk_last_d;
  logic [127:0] store_q [11];

  logic         wr_en;
  logic [3:0]   wr_idx;
  logic [127:0] wr_dat;
  logic [3:0]   prev_idx;
  logic [3:0]   nxt_idx;
  logic [127:0] prev_key;
  logic [31:0]  rot_w, sub_w, w0_n, w1_n, w2_n, w3_n;
  logic [127:0] exp_key;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254, which maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  always_comb begin
    prev_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    prev_key = store_q[prev_idx];
    rot_w    = {prev_key[23:0], prev_key[31:24]};
    sub_w    = '0;
    for (int b = 0; b < 4; b++) sub_w[8*b +: 8] = sbox(rot_w[8*b +: 8]);
    w0_n     = prev_key[127:96] ^ sub_w ^ {rcon(cnt_q), 24'h0};
    w1_n     = prev_key[95:64] ^ w0_n;
    w2_n     = prev_key[63:32] ^ w1_n;
    w3_n     = prev_key[31:0] ^ w2_n;
    exp_key  = {w0_n, w1_n, w2_n, w3_n};
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dec_d        = dec_q;
    busy_d       = busy_q;
    keys_ready_d = keys_ready_q;
    rk_valid_d   = rk_valid_q;
    rk_dat_d     = rk_dat_q;
    rk_idx_d     = rk_idx_q;
    rk_last_d    = rk_last_q;
    wr_en        = 1'b0;
    wr_idx       = cnt_q;
    wr_dat       = exp_key;
    nxt_idx      = dec_q ? rk_idx_q - 4'd1 : rk_idx_q + 4'd1;
    case (state_q)
      IDLE, READY: begin
        if (key_valid_i) begin
          wr_en        = 1'b1;
          wr_idx       = 4'd0;
          wr_dat       = key_i;
          cnt_d        = 4'd1;
          busy_d       = 1'b1;
          keys_ready_d = 1'b0;
          state_d      = EXPAND;
        end else if (state_q == READY && rk_req_i) begin
          dec_d      = decrypt_i;
          rk_idx_d   = decrypt_i ? 4'd10 : 4'd0;
          rk_dat_d   = store_q[decrypt_i ? 4'd10 : 4'd0];
          rk_last_d  = 1'b0;
          rk_valid_d = 1'b1;
          state_d    = STREAM;
        end
      end
      EXPAND: begin
        wr_en = 1'b1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd10) begin
          busy_d       = 1'b0;
          keys_ready_d = 1'b1;
          state_d      = READY;
        end
      end
      STREAM: begin
        // Outputs only move on a handshake, so they hold while the consumer stalls.
        if (rk_ready_i) begin
          if (rk_last_q) begin
            rk_valid_d = 1'b0;
            state_d    = READY;
          end else begin
            rk_idx_d  = nxt_idx;
            rk_dat_d  = store_q[nxt_idx];
            rk_last_d = dec_q ? (nxt_idx == 4'd0) : (nxt_idx == 4'd10);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dec_q        <= 1'b0;
      busy_q       <= 1'b0;
      keys_ready_q <= 1'b0;
      rk_valid_q   <= 1'b0;
      rk_dat_q     <= '0;
      rk_idx_q     <= '0;
      rk_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dec_q        <= dec_d;
      busy_q       <= busy_d;
      keys_ready_q <= keys_ready_d;
      rk_valid_q   <= rk_valid_d;
      rk_dat_q     <= rk_dat_d;
      rk_idx_q     <= rk_idx_d;
      rk_last_q    <= rk_last_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) store_q[i] <= '0;
    end else if (wr_en) begin
      store_q[wr_idx] <= wr_dat;
    end
  end

  assign busy_o       = busy_q;
  assign keys_ready_o = keys_ready_q;
  assign rk_valid_o   = rk_valid_q;
  assign rk_o         = rk_dat_q;
  assign rk_idx_o     = rk_idx_q;
  assign rk_last_o    = rk_last_q;

endmodule
